multicycle_sequencer: RTL and testbench

Parametrised multi-cycle instruction sequencer for the next-generation core. It replaces the per-clock fetch/execute flow with an explicit FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine and owns the PC and the instruction register. It also provides configurable memory wait states, absolute or PC-relative branching, key-confirmed input instructions, halt/resume, and a retired-instruction counter. It sits between instruction memory, the control unit, the register bank and data memory.

---
 rtl/multicycle_sequencer.sv | 154 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer owning the PC and instruction
// register, with memory wait states, key-confirmed input, halt/resume and a retired counter.
module multicycle_sequencer #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned IMM_W       = 16,
  parameter int unsigned MEM_WAIT    = 1,
  parameter int unsigned BRANCH_MODE = 0,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               run,
  input  logic               keyN,
  input  logic [INSTR_W-1:0] instrData,
  input  logic               ctrlBranch,
  input  logic               ctrlJump,
  input  logic               ctrlHalt,
  input  logic               ctrlInput,
  input  logic               ctrlMem,
  input  logic               ctrlMemWrite,
  input  logic               ctrlWrite,
  input  logic               aluBranch,
  output logic [ADDR_W-1:0]  instrAddr,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         phase,
  output logic               regWriteEn,
  output logic               memWriteEn,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StWaitIn    = 3'd5,
    StHalted    = 3'd6
  } state_e;

  state_e            state;
  state_e            exec_next;
  state_e            mem_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] imm_rel;
  logic [ADDR_W-1:0] imm_abs;
  logic [3:0]        wait_cnt;
  logic              key_s1, key_s2, key_d;
  logic              press;
  logic              taken;
  logic              mem_done;
  logic              retire;

  // Sign extension then truncation to ADDR_W keeps only the low immediate bits when IMM_W >= ADDR_W
  if (IMM_W >= ADDR_W) begin : g_imm_trunc
    assign imm_rel = instr[ADDR_W-1:0];
    assign imm_abs = instr[ADDR_W-1:0];
  end else begin : g_imm_ext
    assign imm_rel = ADDR_W'($signed(instr[IMM_W-1:0]));
    assign imm_abs = ADDR_W'(instr[IMM_W-1:0]);
  end

  always_comb begin
    pc_inc   = pc + ADDR_W'(1);
    taken    = (ctrlBranch & aluBranch) | ctrlJump;
    pc_next  = pc_inc;
    if (taken) pc_next = (BRANCH_MODE != 0) ? pc_inc + imm_rel : imm_abs;

    if (ctrlHalt)       exec_next = StHalted;
    else if (ctrlInput) exec_next = StWaitIn;
    else if (ctrlMem)   exec_next = StMemory;
    else if (ctrlWrite) exec_next = StWriteback;
    else                exec_next = StFetch;

    mem_next = ctrlWrite ? StWriteback : StFetch;
    mem_done = (wait_cnt == 4'(MEM_WAIT));
    // Falling edge of the synchronised key; only acted on in WAIT_IN
    press    = key_d & ~key_s2;

    retire = (state == StWriteback) ||
             (state == StExecute && (exec_next == StFetch || exec_next == StHalted)) ||
             (state == StMemory && mem_done && mem_next == StFetch);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= StFetch;
      pc         <= ADDR_W'(RESET_PC);
      instr      <= '0;
      retired    <= '0;
      regWriteEn <= 1'b0;
      memWriteEn <= 1'b0;
      halted     <= 1'b0;
      wait_cnt   <= '0;
      key_s1     <= 1'b1;
      key_s2     <= 1'b1;
      key_d      <= 1'b1;
    end else begin
      key_s1     <= keyN;
      key_s2     <= key_s1;
      key_d      <= key_s2;
      regWriteEn <= 1'b0;
      memWriteEn <= 1'b0;
      if (retire && retired != '1) retired <= retired + COUNT_W'(1);

      unique case (state)
        StFetch: state <= StDecode;
        StDecode: begin
          instr <= instrData;
          state <= StExecute;
        end
        StExecute: begin
          pc         <= pc_next;
          state      <= exec_next;
          wait_cnt   <= '0;
          memWriteEn <= (exec_next == StMemory) && ctrlMemWrite;
          regWriteEn <= (exec_next == StWriteback);
          halted     <= (exec_next == StHalted);
        end
        StMemory: begin
          if (mem_done) begin
            state      <= mem_next;
            regWriteEn <= (mem_next == StWriteback);
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        StWaitIn: begin
          if (press) begin
            state      <= StWriteback;
            regWriteEn <= 1'b1;
          end
        end
        StWriteback: state <= StFetch;
        StHalted: begin
          if (run) begin
            state  <= StFetch;
            halted <= 1'b0;
          end
        end
        default: state <= StFetch;
      endcase
    end
  end

  assign instrAddr = pc;
  assign phase     = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: dut_a (PC-relative, MEM_WAIT=2, 4-bit counter) is checked at every retirement;
// dut_b (absolute branching, defaults) shares the program memory for absolute-jump and counter checks.
module tb_multicycle_sequencer;

  localparam logic [31:0] BR   = 32'h8000_0000;
  localparam logic [31:0] JMP  = 32'h4000_0000;
  localparam logic [31:0] HLT  = 32'h2000_0000;
  localparam logic [31:0] INP  = 32'h1000_0000;
  localparam logic [31:0] MEM  = 32'h0800_0000;
  localparam logic [31:0] MW   = 32'h0400_0000;
  localparam logic [31:0] WR   = 32'h0200_0000;
  localparam logic [31:0] ALUB = 32'h0100_0000;

  logic clock  = 1'b0;
  logic resetN = 1'b1;
  logic run    = 1'b0;
  logic keyN   = 1'b1;

  always #5 clock = ~clock;

  logic [31:0] mem [1024];

  logic [31:0] idata_a, instr_a, idata_b, instr_b;
  logic [9:0]  addr_a, addr_b;
  logic [2:0]  phase_a, phase_b;
  logic        rwe_a, mwe_a, halt_a, rwe_b, mwe_b, halt_b;
  logic [3:0]  ret_a;
  logic [31:0] ret_b;

  // Synchronous instruction memory, one-cycle read latency
  always @(posedge clock) begin
    idata_a <= mem[addr_a];
    idata_b <= mem[addr_b];
  end

  multicycle_sequencer #(
    .ADDR_W(10), .INSTR_W(32), .IMM_W(16), .MEM_WAIT(2), .BRANCH_MODE(1), .RESET_PC(0),
    .COUNT_W(4)
  ) dut_a (
    .clock(clock), .resetN(resetN), .run(run), .keyN(keyN), .instrData(idata_a),
    .ctrlBranch(instr_a[31]), .ctrlJump(instr_a[30]), .ctrlHalt(instr_a[29]),
    .ctrlInput(instr_a[28]), .ctrlMem(instr_a[27]), .ctrlMemWrite(instr_a[26]),
    .ctrlWrite(instr_a[25]), .aluBranch(instr_a[24]),
    .instrAddr(addr_a), .instr(instr_a), .phase(phase_a), .regWriteEn(rwe_a),
    .memWriteEn(mwe_a), .halted(halt_a), .retired(ret_a)
  );

  multicycle_sequencer #(
    .ADDR_W(10), .INSTR_W(32), .IMM_W(16), .MEM_WAIT(1), .BRANCH_MODE(0), .RESET_PC(0),
    .COUNT_W(32)
  ) dut_b (
    .clock(clock), .resetN(resetN), .run(run), .keyN(keyN), .instrData(idata_b),
    .ctrlBranch(instr_b[31]), .ctrlJump(instr_b[30]), .ctrlHalt(instr_b[29]),
    .ctrlInput(instr_b[28]), .ctrlMem(instr_b[27]), .ctrlMemWrite(instr_b[26]),
    .ctrlWrite(instr_b[25]), .aluBranch(instr_b[24]),
    .instrAddr(addr_b), .instr(instr_b), .phase(phase_b), .regWriteEn(rwe_b),
    .memWriteEn(mwe_b), .halted(halt_b), .retired(ret_b)
  );

  typedef struct {
    int pc;
    int ret;
    int lat;
    int regp;
    int memp;
    bit hlt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endfunction

  task automatic push(int pc, int ret, int lat, int regp, int memp, bit hlt);
    exp_t e;
    e.pc = pc; e.ret = ret; e.lat = lat; e.regp = regp; e.memp = memp; e.hlt = hlt;
    sb.push_back(e);
  endtask

  // Monitor: one expected record per retirement (entry to FETCH from EXEC/MEM/WB, or to HALTED)
  int cyc = 0, last_fetch = 0, prev = 0, regp = 0, memp = 0, bad = 0;
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (!resetN) begin
      prev = 0; last_fetch = cyc; regp = 0; memp = 0; bad = 0;
    end else begin
      if (rwe_a) begin
        regp++;
        if (phase_a != 3'd4) bad++;
      end
      if (mwe_a) begin
        memp++;
        if (!(phase_a == 3'd3 && prev != 3)) bad++;
      end
      if ((phase_a == 3'd0 && prev inside {2, 3, 4}) || (phase_a == 3'd6 && prev != 6)) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_retire: phase %0d pc 'h%0h, expected none", phase_a, addr_a);
        end else begin
          e = sb.pop_front();
          chk($sformatf("pc@ret%0d", e.ret), addr_a, e.pc);
          chk($sformatf("retired@pc%0h", e.pc), ret_a, e.ret);
          if (e.lat >= 0) chk($sformatf("latency@pc%0h", e.pc), cyc - last_fetch, e.lat);
          chk($sformatf("reg_pulses@pc%0h", e.pc), regp, e.regp);
          chk($sformatf("mem_pulses@pc%0h", e.pc), memp, e.memp);
          chk($sformatf("halted@pc%0h", e.pc), halt_a, e.hlt);
          chk($sformatf("stray_strobes@pc%0h", e.pc), bad, 0);
        end
        regp = 0; memp = 0; bad = 0;
      end
      if (phase_a == 3'd0) last_fetch = cyc;
      prev = int'(phase_a);
    end
  end

  task automatic restart();
    @(posedge clock);
    #1 resetN = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic release_reset();
    @(posedge clock);
    @(posedge clock);
    #2 resetN = 1'b1;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: %0d retirements still pending, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clock);
  endtask

  task automatic wait_phase(input int p, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clock);
      #1;
      if (phase_a == 3'(p)) found = 1'b1;
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL %s: phase %0d not reached, got %0d", name, p, phase_a);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset state
    #1 resetN = 1'b0;
    #1;
    chk("rst_phase", phase_a, 0);
    chk("rst_pc", addr_a, 0);
    chk("rst_instr", instr_a, 0);
    chk("rst_retired", ret_a, 0);
    chk("rst_regwe", rwe_a, 0);
    chk("rst_memwe", mwe_a, 0);
    chk("rst_halted", halt_a, 0);
    chk("rst_phase_b", phase_b, 0);
    chk("rst_retired_b", ret_b, 0);

    // ALU write then halt
    mem[0] = WR; mem[1] = HLT;
    push(1, 1, 4, 1, 0, 0);
    push(2, 2, 3, 0, 0, 1);
    release_reset();
    drain("alu_write");

    // Relative branch taken from PC 5: 5+1-4 = 2
    restart();
    mem[0] = JMP | 32'd4; mem[5] = BR | ALUB | 32'hFFFC; mem[2] = HLT;
    push(5, 1, 3, 0, 0, 0);
    push(2, 2, 3, 0, 0, 0);
    push(3, 3, 3, 0, 0, 1);
    release_reset();
    drain("branch_taken");

    // Relative branch not taken
    restart();
    mem[0] = JMP | 32'd4; mem[5] = BR | 32'hFFFC; mem[6] = HLT;
    push(5, 1, 3, 0, 0, 0);
    push(6, 2, 3, 0, 0, 0);
    push(7, 3, 3, 0, 0, 1);
    release_reset();
    drain("branch_not_taken");

    // Jump imm 0x123: absolute on dut_b, 0+1+0x123 on dut_a
    restart();
    mem[0] = JMP | 32'h0123; mem[10'h123] = HLT; mem[10'h124] = HLT;
    push(10'h124, 1, 3, 0, 0, 0);
    push(10'h125, 2, 3, 0, 0, 1);
    release_reset();
    drain("jump");
    chk("abs_jump_halted_b", halt_b, 1);
    chk("abs_jump_pc_b", addr_b, 10'h124);
    chk("abs_jump_ret_b", ret_b, 2);

    // 0+1-2 wraps to 0x3FF; the NOP there wraps PC to 0, which then halts
    restart();
    mem[0] = JMP | 32'hFFFE;
    push(10'h3FF, 1, 3, 0, 0, 0);
    push(0, 2, 3, 0, 0, 0);
    push(1, 3, 3, 0, 0, 1);
    release_reset();
    wait_phase(2, "wrap_exec");
    mem[0] = HLT;
    drain("pc_wrap");

    // Store (6 cycles) then load with write (7 cycles) at MEM_WAIT=2
    restart();
    mem[0] = MEM | MW; mem[1] = MEM | WR; mem[2] = HLT;
    push(1, 1, 6, 0, 1, 0);
    push(2, 2, 7, 1, 0, 0);
    push(3, 3, 3, 0, 0, 1);
    release_reset();
    drain("store_load");

    // Input instruction: held key ignored, release ignored, fresh press -> WB after 3 edges
    restart();
    keyN = 1'b0;
    mem[0] = INP | WR; mem[1] = HLT;
    push(1, 1, -1, 1, 0, 0);
    push(2, 2, 3, 0, 0, 1);
    release_reset();
    wait_phase(5, "enter_wait_in");
    repeat (8) @(posedge clock);
    #1 chk("held_key_ignored", phase_a, 5);
    keyN = 1'b1;
    repeat (4) @(posedge clock);
    #1 chk("release_ignored", phase_a, 5);
    keyN = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock);
      #1;
      if (n == 0 && phase_a == 3'd4) n = i;
    end
    chk("press_to_wb", n, 3);
    keyN = 1'b1;
    drain("input");

    // Halt at PC 7, resume with run
    restart();
    mem[7] = HLT; mem[8] = WR; mem[9] = HLT;
    for (int k = 1; k <= 7; k++) push(k, k, 3, 0, 0, 0);
    push(8, 8, 3, 0, 0, 1);
    release_reset();
    drain("halt");
    repeat (5) @(posedge clock);
    #1;
    chk("halt_hold_phase", phase_a, 6);
    chk("halt_hold_flag", halt_a, 1);
    chk("halt_hold_pc", addr_a, 8);
    push(9, 9, 4, 1, 0, 0);
    push(10, 10, 3, 0, 0, 1);
    run = 1'b1;
    @(posedge clock);
    #1 run = 1'b0;
    chk("resume_phase", phase_a, 0);
    chk("resume_pc", addr_a, 8);
    chk("resume_halted", halt_a, 0);
    drain("resume");

    // Reset during MEMORY aborts the store
    restart();
    mem[0] = MEM | MW | WR;
    release_reset();
    wait_phase(3, "enter_memory");
    chk("store_strobe_pre_abort", mwe_a, 1);
    #2 resetN = 1'b0;
    #1;
    chk("abort_phase", phase_a, 0);
    chk("abort_memwe", mwe_a, 0);
    chk("abort_regwe", rwe_a, 0);
    chk("abort_pc", addr_a, 0);
    chk("abort_retired", ret_a, 0);

    // Counter saturation: 17 NOPs then halt, 4-bit counter stops at 15
    restart();
    mem[17] = HLT;
    for (int k = 1; k <= 17; k++) push(k, (k > 15) ? 15 : k, 3, 0, 0, 0);
    push(18, 15, 3, 0, 0, 1);
    release_reset();
    drain("saturate");
    chk("sat_retired_a", ret_a, 15);
    chk("sat_retired_b", ret_b, 18);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
